// File: rtl/mont_pkg.sv
// Shared types and defaults for the bit-serial Montgomery multiplier controller.
package mont_pkg;

    localparam int N_DEF  = 512;
    localparam int AW_DEF = N_DEF + 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TEST_A,
        S_ADD_B,
        S_WAIT_B,
        S_TEST_C,
        S_ADD_M,
        S_WAIT_M,
        S_NEXT,
        S_SUB,
        S_WAIT_SUB,
        S_DONE
    } state_t;

    // Counter must hold the value N reached after the final increment.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/montgomery_ctrl_if.sv
// Host request/response and adder control bundle for montgomery_ctrl.
interface montgomery_ctrl_if
    import mont_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
);
    logic          start;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [N-1:0]  in_m;
    logic [N-1:0]  result;
    logic          done;
    logic          add_start;
    logic          add_subtract;
    logic          add_shift;
    logic [AW-1:0] add_in_a;
    logic [AW-1:0] add_in_b;
    logic [AW:0]   add_result;
    logic          add_done;

    // Controller side.
    modport slave (
        input  start, in_a, in_b, in_m, add_result, add_done,
        output result, done, add_start, add_subtract, add_shift, add_in_a, add_in_b
    );

    // Host plus adder side.
    modport master (
        output start, in_a, in_b, in_m, add_result, add_done,
        input  result, done, add_start, add_subtract, add_shift, add_in_a, add_in_b
    );
endinterface

// File: rtl/montgomery_ctrl.sv
// Sequences an external shared adder to compute a*b*2^-N mod m bit-serially.
module montgomery_ctrl
    import mont_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    montgomery_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(N);

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_m;
    logic [AW-1:0] r_c;
    logic [CW-1:0] r_i;
    logic          w_last;

    assign w_last = (r_i == CW'(N - 1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_c     <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a <= bus.in_a;
                        r_b <= bus.in_b;
                        r_m <= bus.in_m;
                        r_c <= '0;
                        r_i <= '0;
                    end
                end
                S_WAIT_B: begin
                    if (bus.add_done) begin
                        r_c <= bus.add_result[AW-1:0];
                    end
                end
                S_TEST_C: begin
                    if (!r_c[0]) begin
                        r_c <= r_c >> 1;
                    end
                end
                S_WAIT_M: begin
                    // The adder has already halved C+M; the sum never exceeds AW-1 bits.
                    if (bus.add_done) begin
                        r_c <= bus.add_result[AW-1:0];
                    end
                end
                S_NEXT: begin
                    r_a <= r_a >> 1;
                    r_i <= r_i + 1'b1;
                end
                S_WAIT_SUB: begin
                    // Carry out of the subtraction means no borrow, i.e. C >= M.
                    if (bus.add_done && bus.add_result[AW]) begin
                        r_c <= bus.add_result[AW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_state_next = S_TEST_A;
            S_TEST_A:   w_state_next = r_a[0] ? S_ADD_B : S_TEST_C;
            S_ADD_B:    w_state_next = S_WAIT_B;
            S_WAIT_B:   if (bus.add_done) w_state_next = S_TEST_C;
            S_TEST_C:   w_state_next = r_c[0] ? S_ADD_M : S_NEXT;
            S_ADD_M:    w_state_next = S_WAIT_M;
            S_WAIT_M:   if (bus.add_done) w_state_next = S_NEXT;
            S_NEXT:     w_state_next = w_last ? S_SUB : S_TEST_A;
            S_SUB:      w_state_next = S_WAIT_SUB;
            S_WAIT_SUB: if (bus.add_done) w_state_next = S_DONE;
            S_DONE:     if (bus.start) w_state_next = S_TEST_A;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Operands and mode stay driven through each wait state; the adder reads them chunk-wise.
    always_comb begin
        bus.done         = 1'b0;
        bus.result       = '0;
        bus.add_start    = 1'b0;
        bus.add_subtract = 1'b0;
        bus.add_shift    = 1'b0;
        bus.add_in_a     = '0;
        bus.add_in_b     = '0;
        case (r_state)
            S_ADD_B, S_WAIT_B: begin
                bus.add_start = (r_state == S_ADD_B);
                bus.add_in_a  = r_c;
                bus.add_in_b  = AW'(r_b);
            end
            S_ADD_M, S_WAIT_M: begin
                bus.add_start = (r_state == S_ADD_M);
                bus.add_shift = 1'b1;
                bus.add_in_a  = r_c;
                bus.add_in_b  = AW'(r_m);
            end
            S_SUB, S_WAIT_SUB: begin
                bus.add_start    = (r_state == S_SUB);
                bus.add_subtract = 1'b1;
                bus.add_in_a     = r_c;
                bus.add_in_b     = AW'(r_m);
            end
            S_DONE: begin
                bus.done   = 1'b1;
                bus.result = r_c[N-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_montgomery_ctrl.sv
// Directed bench for montgomery_ctrl with a behavioural multi-cycle adder and a result scoreboard.
module tb_montgomery_ctrl;
    import mont_pkg::*;

    localparam int N  = 512;
    localparam int AW = 514;

    typedef struct {
        logic [N-1:0] abm;
        logic [N-1:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    montgomery_ctrl_if #(.N(N), .AW(AW)) bus ();

    montgomery_ctrl #(.N(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Adder model: add_done pulses lat cycles after the add_start cycle.
    int lat = 4;
    int r_cnt = 0;
    always @(posedge clk) begin
        if (rst)                r_cnt <= 0;
        else if (bus.add_start) r_cnt <= lat;
        else if (r_cnt > 0)     r_cnt <= r_cnt - 1;
    end
    assign bus.add_done = (r_cnt == 1);
    assign bus.add_result =
        bus.add_subtract ? ({1'b0, bus.add_in_a} + {1'b0, ~bus.add_in_b} + {{AW{1'b0}}, 1'b1}) :
        bus.add_shift    ? (({1'b0, bus.add_in_a} + {1'b0, bus.add_in_b}) >> 1) :
                           ({1'b0, bus.add_in_a} + {1'b0, bus.add_in_b});

    // Operand stability and pulse counting.
    logic [AW-1:0] cap_a, cap_b;
    logic in_txn = 1'b0;
    int stab_viol = 0;
    int n_plain = 0;
    int n_sub = 0;
    always @(posedge clk) begin
        if (rst) begin
            in_txn <= 1'b0;
        end else if (bus.add_start) begin
            cap_a  <= bus.add_in_a;
            cap_b  <= bus.add_in_b;
            in_txn <= 1'b1;
            if (bus.add_subtract) n_sub <= n_sub + 1;
            else                  n_plain <= n_plain + 1;
        end else if (in_txn) begin
            if (bus.add_in_a !== cap_a || bus.add_in_b !== cap_b) stab_viol <= stab_viol + 1;
            if (bus.add_done) in_txn <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        p = p % {{N{1'b0}}, m};
        return p[N-1:0];
    endfunction

    // r * 2^N mod m: maps a Montgomery result back to plain a*b mod m.
    function automatic logic [N-1:0] unmont(input logic [N-1:0] r, input logic [N-1:0] m);
        logic [2*N-1:0] p;
        p = {r, {N{1'b0}}} % {{N{1'b0}}, m};
        return p[N-1:0];
    endfunction

    task automatic gen(output logic [N-1:0] a, output logic [N-1:0] b, output logic [N-1:0] m);
        m = rand_wide();
        m[N-1] = 1'b1;
        m[0] = 1'b1;
        a = rand_wide() % m;
        a[N-1] = 1'b0;
        b = rand_wide() % m;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
        exp_t e;
        e.abm = mulmod(a, b, m);
        e.m = m;
        sb.push_back(e);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_m = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // cycles counts from the start cycle through the first done cycle inclusive.
    task automatic finish_op(input string tag, output int cycles);
        int cyc;
        exp_t e;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        cycles = cyc + 1;
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=done_low expected=done_high", tag);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lt_m"}, 520'(bus.result < e.m), 520'(1));
            check({tag, "_golden"}, 520'(unmont(bus.result, e.m)), 520'(e.abm));
            check({tag, "_maxlat"}, 520'(cycles <= 1 + N * (6 + 2 * lat) + 2 + lat), 520'(1));
            $display("op %s: result=%0h cycles=%0d L=%0d", tag, bus.result, cycles, lat);
        end
    endtask

    initial begin
        logic [N-1:0] a, b, m;
        int cyc, p0, s0, k;
        exp_t dropped;

        bus.start = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_m = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", 520'(bus.done), 520'(0));
        check("rst_result", 520'(bus.result), 520'(0));
        check("rst_add_start", 520'(bus.add_start), 520'(0));
        check("rst_add_sub", 520'(bus.add_subtract), 520'(0));
        check("rst_add_shift", 520'(bus.add_shift), 520'(0));
        check("rst_add_in_a", 520'(bus.add_in_a), 520'(0));
        check("rst_add_in_b", 520'(bus.add_in_b), 520'(0));
        rst = 1'b0;
        @(negedge clk);

        // 35 * 2^-512 mod 13 = 1
        lat = 4;
        issue(N'(5), N'(7), N'(13));
        finish_op("small", cyc);
        check("small_exact", 520'(bus.result), 520'(1));
        repeat (3) @(negedge clk);
        check("hold_done", 520'(bus.done), 520'(1));
        check("hold_result", 520'(bus.result), 520'(1));

        // a = 0: only TEST_A/TEST_C/NEXT per iteration, then a single subtract.
        p0 = n_plain;
        s0 = n_sub;
        issue(N'(0), N'(7), N'(13));
        finish_op("zero", cyc);
        check("zero_exact", 520'(bus.result), 520'(0));
        check("zero_min_latency", 520'(cyc), 520'(1 + 3 * N + 2 + lat));
        check("zero_add_pulses", 520'(n_plain - p0), 520'(0));
        check("zero_sub_pulses", 520'(n_sub - s0), 520'(1));

        for (k = 0; k < 3; k++) begin
            lat = (k == 0) ? 1 : (k == 1) ? 4 : 9;
            gen(a, b, m);
            issue(a, b, m);
            finish_op($sformatf("rand%0d", k), cyc);
        end

        // Stray start while waiting on the adder in iteration 100.
        lat = 1;
        gen(a, b, m);
        a[100] = 1'b1;
        issue(a, b, m);
        cyc = 0;
        while (!(dut.r_state == S_WAIT_B && dut.r_i == 100) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore_found_wait_b", 520'(dut.r_state == S_WAIT_B), 520'(1));
        bus.in_a = rand_wide();
        bus.in_b = rand_wide();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("ignore", cyc);

        // Reset pulse partway through iteration 300.
        gen(a, b, m);
        issue(a, b, m);
        cyc = 0;
        while (dut.r_i != 300 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 520'(dut.r_state), 520'(S_IDLE));
        check("midrst_done", 520'(bus.done), 520'(0));
        check("midrst_result", 520'(bus.result), 520'(0));
        check("midrst_add_start", 520'(bus.add_start), 520'(0));
        if (sb.size() > 0) dropped = sb.pop_front();
        gen(a, b, m);
        issue(a, b, m);
        finish_op("after_rst", cyc);

        // Back-to-back: restart straight from DONE.
        gen(a, b, m);
        issue(a, b, m);
        finish_op("b2b_first", cyc);
        gen(a, b, m);
        issue(a, b, m);
        check("b2b_done_drop", 520'(bus.done), 520'(0));
        finish_op("b2b_second", cyc);

        check("operand_stability", 520'(stab_viol), 520'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
